// File: rtl/slicem_cfg_pkg.sv
// Shared types and constants for the SLICEM configuration loader.
// Chain geometry helpers and CRC-8 constants live here.
package slicem_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  function automatic int chain_len(
    input int s_xx_base,
    input int num_luts
  );
    return num_luts * 2 * ((1 << s_xx_base) + 1) + 1;
  endfunction

  function automatic int n_words(
    input int s_xx_base,
    input int num_luts,
    input int word_w
  );
    return (chain_len(s_xx_base, num_luts) + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/slicem_cfg_crc8.sv
// Bit-serial CRC-8, MSB-first register, polynomial from slicem_cfg_pkg.
// Used by slicem_cfg_loader only when SLICEM_CFG_CRC_EN is defined.
module slicem_cfg_crc8
  import slicem_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic       bit_in_i,
  output logic [7:0] crc_out_o
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[7] ^ bit_in_i;
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC8_INIT;
    end else if (enable_i) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= CRC8_INIT;
    else     crc_q <= crc_d;
  end

  assign crc_out_o = crc_q;

endmodule

// File: rtl/slicem_cfg_loader.sv
// Serialises a word stream into a slice config chain, LSB of each word first.
// Define SLICEM_CFG_CRC_EN to add a trailing CRC-8 check word.
module slicem_cfg_loader
  import slicem_cfg_pkg::*;
#(
  parameter int S_XX_BASE = 4,
  parameter int NUM_LUTS  = 4,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_bit,
  output logic              cfg_en,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int CHAIN_LEN = chain_len(S_XX_BASE, NUM_LUTS);
  localparam int RW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [BW-1:0]     bits_q, bits_d;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    rem_d      = rem_q;
    bits_d     = bits_q;
    word_ready = 1'b0;
    cfg_en     = 1'b0;
    cfg_bit    = 1'b0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          rem_d   = RW'(CHAIN_LEN);
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        word_ready = !abort;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (word_valid) begin
          sreg_d  = word_in;
          bits_d  = (int'(rem_q) < WORD_W) ? BW'(rem_q) : BW'(WORD_W);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cfg_en  = 1'b1;
        cfg_bit = sreg_q[0];
        sreg_d  = sreg_q >> 1;
        bits_d  = bits_q - BW'(1);
        rem_d   = rem_q - RW'(1);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rem_q == RW'(1)) begin
`ifdef SLICEM_CFG_CRC_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else if (bits_q == BW'(1)) begin
          state_d = ST_FETCH;
        end
      end
      ST_CHECK: begin
`ifdef SLICEM_CFG_CRC_EN
        word_ready = !abort;
        if (abort) state_d = ST_IDLE;
        else if (word_valid) state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      rem_q   <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
      bits_q  <= bits_d;
    end
  end

`ifdef SLICEM_CFG_CRC_EN
  logic [7:0] crc;
  logic       crc_clr, chk_acc;
  logic       err_q, err_d;

  assign crc_clr = (state_q == ST_IDLE) && start && !abort;
  assign chk_acc = (state_q == ST_CHECK) && word_valid && word_ready;

  slicem_cfg_crc8 u_crc (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (crc_clr),
    .enable_i  (cfg_en),
    .bit_in_i  (cfg_bit),
    .crc_out_o (crc)
  );

  // Error flag survives DONE/IDLE and only a new accepted start clears it.
  always_comb begin
    err_d = err_q;
    if (crc_clr)      err_d = 1'b0;
    else if (chk_acc) err_d = (word_in[7:0] != crc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_slicem_cfg_loader.sv
// Randomised self-checking bench for slicem_cfg_loader at default parameters.
// A bitstream model built from the fed words is checked against cfg_bit.
module tb_slicem_cfg_loader;

  localparam int CL = 4 * 2 * 17 + 1;
  localparam int NW = (CL + 7) / 8;
`ifdef SLICEM_CFG_CRC_EN
  localparam int CX = 1;
`else
  localparam int CX = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] word_in = 8'h00;
  logic       word_valid = 1'b0;
  logic       word_ready, cfg_bit, cfg_en, busy, done, cfg_err;

  slicem_cfg_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .cfg_bit    (cfg_bit),
    .cfg_en     (cfg_en),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] words [0:NW];
  bit         stream [0:CL-1];
  int         bit_idx = 0;
  int         passes = 0;
  int         checks = 0;
  int         r_done, r_en, r_dones, r_gap, r_end;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [7:0] crc8_of_stream();
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < CL; i++) begin
      fb = c[7] ^ stream[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic build(input bit a5, input bit flip);
    for (int i = 0; i < NW; i++)
      words[i] = a5 ? 8'hA5 : 8'($urandom);
    if (a5) words[NW-1] = 8'h01;
    for (int i = 0; i < CL; i++)
      stream[i] = words[i / 8][i % 8];
    words[NW] = crc8_of_stream() ^ {7'b0, flip};
  endtask

  // Per-cycle compare against the bitstream model.
  always @(negedge clk) begin
    if (cfg_en) begin
      chk("en_busy", busy, 1);
      if (bit_idx < CL) chk("cfg_bit", cfg_bit, stream[bit_idx]);
      else chk("en_overrun", bit_idx, CL - 1);
      bit_idx++;
    end
    if (done) chk("done_full", bit_idx, CL);
    if (!busy) chk("idle_quiet", {word_ready, cfg_en, done}, 0);
  end

  task automatic run_load(input int stall_len, input int abort_at,
                          input int mid_start, input bit rnd);
    int widx, stl, k, s0, ab_cyc;
    bit ab;
    widx = 0; stl = stall_len; k = 0; ab = 0; ab_cyc = 0;
    r_done = -1; r_en = 0; r_dones = 0; r_gap = -1; r_end = -1;
    @(negedge clk);
    start   = 1'b1;
    bit_idx = 0;
    @(negedge clk);
    start = 1'b0;
    s0 = cyc;
    while (k < 600) begin
      if (!busy) begin
        r_end = cyc - s0 + 1;
        r_gap = cyc - ab_cyc;
        break;
      end
      if (cfg_en) r_en++;
      if (done) begin
        r_dones++;
        r_done = cyc - s0 + 1;
      end
      if (abort_at > 0 && !ab && r_en == abort_at) begin
        abort = 1'b1; ab = 1'b1; ab_cyc = cyc;
      end else begin
        abort = 1'b0;
      end
      start = (k == mid_start);
      if (rnd) word_valid = ($urandom_range(0, 3) != 0) && (widx < NW + CX);
      else if (widx == 4 && stl > 0) word_valid = 1'b0;
      else word_valid = (widx < NW + CX);
      word_in = (widx <= NW) ? words[widx] : 8'h00;
      #1;
      if (word_valid && word_ready) widx++;
      if (!rnd && widx == 4 && stl > 0 && word_ready && !word_valid) begin
        stl--;
        chk("stall_en_low", cfg_en, 0);
      end
      @(negedge clk);
      k++;
    end
    abort = 1'b0; start = 1'b0; word_valid = 1'b0;
    if (k >= 600) chk("load_timeout", k, 0);
  endtask

  initial begin
    int widx, en;
    build(1'b1, 1'b0);
    chk("pin_s0", stream[0], 1);
    chk("pin_s1", stream[1], 0);
    chk("pin_s7", stream[7], 1);
    chk("pin_s135", stream[135], 1);
    chk("pin_last", stream[CL-1], 1);

    repeat (3) @(negedge clk);
    chk("reset_outs", {word_ready, cfg_bit, cfg_en, busy, done, cfg_err}, 0);
    rst = 1'b0;

    run_load(0, 0, -1, 1'b0);
    chk("full_en", r_en, CL);
    chk("full_done_cyc", r_done, 156 + CX);
    chk("full_dones", r_dones, 1);
    chk("full_busy_fall", r_end, r_done + 1);
    chk("full_err", cfg_err, 0);

    run_load(3, 0, -1, 1'b0);
    chk("bp_en", r_en, CL);
    chk("bp_done_cyc", r_done, 159 + CX);
    chk("bp_dones", r_dones, 1);

    build(1'b0, 1'b0);
    run_load(0, 40, -1, 1'b0);
    chk("abort_en", r_en, 40);
    chk("abort_dones", r_dones, 0);
    chk("abort_gap", r_gap, 1);
    chk("abort_en_after", cfg_en, 0);
    repeat (5) @(negedge clk);
    chk("abort_quiet", {busy, done}, 0);
    build(1'b0, 1'b0);
    run_load(0, 0, -1, 1'b0);
    chk("reload_en", r_en, CL);
    chk("reload_dones", r_dones, 1);

    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {busy, word_ready}, 0);

    build(1'b0, 1'b0);
    run_load(0, 0, 50, 1'b0);
    chk("busy_start_dones", r_dones, 1);
    chk("busy_start_cyc", r_done, 156 + CX);

    for (int n = 0; n < 3; n++) begin
      build(1'b0, 1'b0);
      run_load(0, 0, -1, 1'b1);
      chk("rnd_en", r_en, CL);
      chk("rnd_dones", r_dones, 1);
      chk("rnd_err", cfg_err, 0);
    end

`ifdef SLICEM_CFG_CRC_EN
    build(1'b0, 1'b1);
    run_load(0, 0, -1, 1'b0);
    chk("crc_bad_err", cfg_err, 1);
    chk("crc_bad_dones", r_dones, 1);
    repeat (3) @(negedge clk);
    chk("crc_err_held", cfg_err, 1);
    start = 1'b1; bit_idx = 0;
    @(negedge clk);
    start = 1'b0;
    chk("crc_err_clr", cfg_err, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`endif

    build(1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; bit_idx = 0;
    @(negedge clk);
    start = 1'b0; widx = 0; en = 0;
    for (int k = 0; k < 400 && en < 20; k++) begin
      word_valid = 1'b1;
      word_in = words[widx];
      #1;
      if (word_ready) widx++;
      @(negedge clk);
      if (cfg_en) en++;
    end
    chk("rst_mid_shift", cfg_en, 1);
    #2 rst = 1'b1;
    word_valid = 1'b0;
    #1;
    chk("async_rst_outs", {word_ready, cfg_bit, cfg_en, busy, done, cfg_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_fetch", {word_ready, cfg_en, busy}, 3'b101);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("post_rst_abort", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/slicem_cfg_loader.md
Name: slicem_cfg_loader

Overview:
- Sequences configuration of one memory logic slice.
- Accepts a configuration bitstream as WORD_W-bit words over a valid/ready stream and serialises it, one bit per cycle, into the slice's configuration shift chain.
- The chain is all LUT configs plus the carry-chain-use bit. The block drives the chain's serial data and its config enable (cen).
- Reports busy/done, and optionally checks a trailing CRC.

Parameters:
- S_XX_BASE, 4, LUT input base; CFG_SIZE = 2**S_XX_BASE+1.
- NUM_LUTS, 4, LUTs in the slice.
- WORD_W, 8, input word width; must be >=1, and >=8 when the CRC option is compiled in.
- Derived constants (not overridable):
  - CHAIN_LEN = NUM_LUTS*2*CFG_SIZE+1 (137 at defaults).
  - N_WORDS = ceil(CHAIN_LEN/WORD_W) (18 at defaults).

Ports:
- clk  in  1  block clock; also the clock of the slice config chain (cclk).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  cancel an in-progress load.
- word_in  in  WORD_W  config word; LSB is shifted first.
- word_valid  in  1  word_in valid.
- word_ready  out  1  block accepts word_in this cycle.
- cfg_bit  out  1  serial config data to the chain.
- cfg_en  out  1  chain shift enable (drives cen).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at completion.
- cfg_err  out  1  CRC mismatch flag; sticky until next accepted start.

Behaviour:
- Reset (asynchronous): state IDLE; word_ready, cfg_bit, cfg_en, busy, done and cfg_err all 0; counters 0.
- After reset mid-load, the chain contents are undefined and a full reload is required.
- States: IDLE, FETCH, SHIFT, CHECK (CRC option only), DONE.
- IDLE:
  - start=1 and abort=0 → clear cfg_err, set remaining=CHAIN_LEN, go to FETCH.
  - start=1 together with abort=1 → ignored.
- FETCH:
  - word_ready=1 (combinational from state).
  - On word_valid & word_ready: capture word_in into the shift register, set word_bits = min(WORD_W, remaining), go to SHIFT.
  - No valid → stay in FETCH; cfg_en=0, so the chain holds.
- SHIFT:
  - cfg_en=1, cfg_bit = sreg[0]. Each cycle: sreg >>= 1, word_bits--, remaining--.
  - When remaining reaches 0 → DONE, or CHECK when the CRC option is compiled in.
  - Else, when word_bits reaches 0 → FETCH.
- Partial last word: only the low (CHAIN_LEN mod WORD_W) bits are shifted; upper bits are discarded. At defaults, word 18 shifts only bit 0.
- Bit order: first bit shifted lands at the far end of the chain (LUT NUM_LUTS-1 MSB side); the use_cc bit is the last bit shifted.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 in DONE.
- Latency (word_valid held high, no CRC): done asserts in cycle N_WORDS+CHAIN_LEN+1 after the start edge. At defaults this is cycle 156.
- abort:
  - In FETCH, SHIFT or CHECK: next state is IDLE, cfg_en=0 from the next cycle, no done pulse, no word accepted in that cycle.
  - abort in DONE: done still pulses.
- start while busy: ignored.
- cfg_en is never high outside SHIFT, and is never high for more than CHAIN_LEN cycles per load.

Optional Feature:
- Macro: SLICEM_CFG_CRC_EN.
- With the macro:
  - A serial CRC-8 (poly 0x07, init 0x00, MSB-first register, fed with each cfg_bit as it is shifted) runs during SHIFT.
  - After the last chain bit the block enters CHECK: word_ready=1, and it accepts one extra word whose bits [7:0] are the expected CRC.
  - On acceptance: cfg_err = (expected != computed), go to DONE.
  - cfg_err is held until the next accepted start.
- Without the macro: no CHECK state, no extra word, cfg_err tied to 0.

Decomposition:
- Package slicem_cfg_pkg:
  - state enum;
  - functions computing CHAIN_LEN and N_WORDS from S_XX_BASE/NUM_LUTS/WORD_W;
  - CRC8_POLY = 8'h07, CRC8_INIT = 8'h00.
- One sub-module, slicem_cfg_crc8: serial CRC-8 with clear, enable, bit_in and crc_out; instantiated only under SLICEM_CFG_CRC_EN.

Test Plan:
- Full load: defaults, word_valid always high, 18 words 0xA5… (last word 0x01) → exactly 137 cfg_en cycles; the cfg_bit sequence matches the LSB-first concatenation truncated to 137 bits; done is a single pulse in cycle 156; busy then falls.
- Backpressure: deassert word_valid for 3 cycles before word 5 → cfg_en stays low during the stall and no bits are lost; done is delayed by exactly 3 cycles (cycle 159).
- Abort: assert abort in the 40th SHIFT cycle → cfg_en=0 next cycle, no done, busy=0; a subsequent start performs a complete 137-bit load.
- Async reset: assert rst mid-SHIFT between clock edges → all outputs 0 immediately; after release, a start with no words leaves the block in FETCH with word_ready=1 and cfg_en=0.
- Start edge cases: start+abort together in IDLE → stays IDLE. start pulsed while busy → ignored, and exactly one done pulse results.
- CRC (SLICEM_CFG_CRC_EN): full load followed by the correct CRC word → done with cfg_err=0. Repeat with bit 0 of the CRC flipped → cfg_err=1, held until the next start, which clears it.
